// File: rtl/udma_uart_cfg_seq.sv
// udma_uart_cfg_seq: register-bus master that programs the udma UART via its
// cfg port. A start pulse latches the request fields. The block then writes
// SETUP, the optional RX channel registers and the TX channel registers, and
// polls STATUS until TX is idle.
//
// Ports:
//   sys_clk_i, rst_i         clock, asynchronous active-high reset
//   start_i, abort_i         start pulse (IDLE only), level abort request
//   setup_i, rx_en_i, rx_*_i, tx_*_i  request fields, latched on start
//   cfg_*_o / cfg_*_i        UART register port (valid/ready handshake)
//   busy_o, done_o           sequence running, one-cycle completion pulse
//   err_o, err_code_o        sticky error: 1 timeout, 2 abort, 3 readback
//
// Optional: define UDMA_UART_CFG_SEQ_READBACK_EN to read back and compare each
// SETUP/SADDR/SIZE write before continuing.
module udma_uart_cfg_seq #(
    parameter int unsigned L2_AWIDTH_NOAL = 12,
    parameter int unsigned TRANS_SIZE     = 16,
    parameter int unsigned POLL_TIMEOUT   = 1024,
    parameter logic [4:0]  ADDR_RX_SADDR  = 5'h00,
    parameter logic [4:0]  ADDR_RX_SIZE   = 5'h01,
    parameter logic [4:0]  ADDR_RX_CFG    = 5'h02,
    parameter logic [4:0]  ADDR_TX_SADDR  = 5'h04,
    parameter logic [4:0]  ADDR_TX_SIZE   = 5'h05,
    parameter logic [4:0]  ADDR_TX_CFG    = 5'h06,
    parameter logic [4:0]  ADDR_STATUS    = 5'h08,
    parameter logic [4:0]  ADDR_SETUP     = 5'h09
) (
    input  logic                      sys_clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [31:0]               setup_i,
    input  logic                      rx_en_i,
    input  logic [L2_AWIDTH_NOAL-1:0] rx_saddr_i,
    input  logic [TRANS_SIZE-1:0]     rx_size_i,
    input  logic [L2_AWIDTH_NOAL-1:0] tx_saddr_i,
    input  logic [TRANS_SIZE-1:0]     tx_size_i,
    output logic [31:0]               cfg_data_o,
    output logic [4:0]                cfg_addr_o,
    output logic                      cfg_valid_o,
    output logic                      cfg_rwn_o,
    input  logic                      cfg_ready_i,
    input  logic [31:0]               cfg_data_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o
);

    localparam int unsigned CNT_W       = $clog2(POLL_TIMEOUT + 1);
    localparam logic [31:0] CFG_EN_WORD = 32'h0000_0010;
    localparam logic [1:0]  ERR_NONE    = 2'd0;
    localparam logic [1:0]  ERR_TIMEOUT = 2'd1;
    localparam logic [1:0]  ERR_ABORT   = 2'd2;
`ifdef UDMA_UART_CFG_SEQ_READBACK_EN
    localparam logic [1:0]  ERR_RDBK    = 2'd3;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_W_SETUP, S_W_RX_SADDR, S_W_RX_SIZE, S_W_RX_CFG,
        S_W_TX_SADDR, S_W_TX_SIZE, S_W_TX_CFG, S_POLL, S_DONE
`ifdef UDMA_UART_CFG_SEQ_READBACK_EN
        , S_R_SETUP, S_R_RX_SADDR, S_R_RX_SIZE, S_R_TX_SADDR, S_R_TX_SIZE
`endif
    } state_t;

    state_t                    state_q, state_d, succ, after_setup;
    logic [31:0]               setup_q;
    logic                      rx_en_q;
    logic [L2_AWIDTH_NOAL-1:0] rx_saddr_q, tx_saddr_q;
    logic [TRANS_SIZE-1:0]     rx_size_q, tx_size_q;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [31:0]               data_d, req_wdata;
    logic [4:0]                addr_d, req_addr;
    logic                      valid_d, rwn_d, busy_d, done_d, err_d, req_rwn;
    logic [1:0]                code_d, err_val;
    logic                      err_hit, latch_c;

`ifndef UDMA_UART_CFG_SEQ_READBACK_EN
    // Only the TX-busy status bit is consumed without readback.
    logic data_unused_c;
    assign data_unused_c = ^cfg_data_i[31:1];
`endif

    assign after_setup = rx_en_q ? S_W_RX_SADDR : S_W_TX_SADDR;

    // Per-state register address, write value (also readback reference) and successor.
    always_comb begin
        req_addr  = ADDR_STATUS;
        req_wdata = '0;
        req_rwn   = 1'b1;
        succ      = S_IDLE;
        case (state_q)
`ifdef UDMA_UART_CFG_SEQ_READBACK_EN
            S_W_SETUP:    begin req_addr = ADDR_SETUP;    req_wdata = setup_q;           req_rwn = 1'b0; succ = S_R_SETUP;    end
            S_W_RX_SADDR: begin req_addr = ADDR_RX_SADDR; req_wdata = 32'(rx_saddr_q);   req_rwn = 1'b0; succ = S_R_RX_SADDR; end
            S_W_RX_SIZE:  begin req_addr = ADDR_RX_SIZE;  req_wdata = 32'(rx_size_q);    req_rwn = 1'b0; succ = S_R_RX_SIZE;  end
            S_W_TX_SADDR: begin req_addr = ADDR_TX_SADDR; req_wdata = 32'(tx_saddr_q);   req_rwn = 1'b0; succ = S_R_TX_SADDR; end
            S_W_TX_SIZE:  begin req_addr = ADDR_TX_SIZE;  req_wdata = 32'(tx_size_q);    req_rwn = 1'b0; succ = S_R_TX_SIZE;  end
            S_R_SETUP:    begin req_addr = ADDR_SETUP;    req_wdata = setup_q;           succ = after_setup;   end
            S_R_RX_SADDR: begin req_addr = ADDR_RX_SADDR; req_wdata = 32'(rx_saddr_q);   succ = S_W_RX_SIZE;   end
            S_R_RX_SIZE:  begin req_addr = ADDR_RX_SIZE;  req_wdata = 32'(rx_size_q);    succ = S_W_RX_CFG;    end
            S_R_TX_SADDR: begin req_addr = ADDR_TX_SADDR; req_wdata = 32'(tx_saddr_q);   succ = S_W_TX_SIZE;   end
            S_R_TX_SIZE:  begin req_addr = ADDR_TX_SIZE;  req_wdata = 32'(tx_size_q);    succ = S_W_TX_CFG;    end
`else
            S_W_SETUP:    begin req_addr = ADDR_SETUP;    req_wdata = setup_q;           req_rwn = 1'b0; succ = after_setup;  end
            S_W_RX_SADDR: begin req_addr = ADDR_RX_SADDR; req_wdata = 32'(rx_saddr_q);   req_rwn = 1'b0; succ = S_W_RX_SIZE;  end
            S_W_RX_SIZE:  begin req_addr = ADDR_RX_SIZE;  req_wdata = 32'(rx_size_q);    req_rwn = 1'b0; succ = S_W_RX_CFG;   end
            S_W_TX_SADDR: begin req_addr = ADDR_TX_SADDR; req_wdata = 32'(tx_saddr_q);   req_rwn = 1'b0; succ = S_W_TX_SIZE;  end
            S_W_TX_SIZE:  begin req_addr = ADDR_TX_SIZE;  req_wdata = 32'(tx_size_q);    req_rwn = 1'b0; succ = S_W_TX_CFG;   end
`endif
            S_W_RX_CFG:   begin req_addr = ADDR_RX_CFG;   req_wdata = CFG_EN_WORD;       req_rwn = 1'b0; succ = S_W_TX_SADDR; end
            S_W_TX_CFG:   begin req_addr = ADDR_TX_CFG;   req_wdata = CFG_EN_WORD;       req_rwn = 1'b0; succ = S_POLL;       end
            S_POLL:       begin succ = S_DONE; end
            default:      ;
        endcase
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        valid_d = cfg_valid_o;
        addr_d  = cfg_addr_o;
        data_d  = cfg_data_o;
        rwn_d   = cfg_rwn_o;
        busy_d  = busy_o;
        done_d  = 1'b0;
        err_d   = err_o;
        code_d  = err_code_o;
        cnt_d   = cnt_q;
        latch_c = 1'b0;
        err_hit = 1'b0;
        err_val = ERR_NONE;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start_i && !abort_i) begin
                    latch_c = 1'b1;
                    state_d = S_W_SETUP;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                if (!cfg_valid_o) begin
                    // No transaction pending: abort may cut in before issuing.
                    if (abort_i) begin
                        err_hit = 1'b1;
                        err_val = ERR_ABORT;
                    end else begin
                        valid_d = 1'b1;
                        addr_d  = req_addr;
                        data_d  = req_rwn ? 32'h0 : req_wdata;
                        rwn_d   = req_rwn;
                    end
                end else if (cfg_ready_i) begin
                    valid_d = 1'b0;
                    state_d = succ;
                    if (state_q == S_POLL && cfg_data_i[0]) begin
                        if (cnt_q + CNT_W'(1) == CNT_W'(POLL_TIMEOUT)) begin
                            err_hit = 1'b1;
                            err_val = ERR_TIMEOUT;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = S_POLL;
                        end
                    end
`ifdef UDMA_UART_CFG_SEQ_READBACK_EN
                    if (req_rwn && state_q != S_POLL && cfg_data_i != req_wdata) begin
                        err_hit = 1'b1;
                        err_val = ERR_RDBK;
                    end
`endif
                    if (abort_i && !err_hit) begin
                        err_hit = 1'b1;
                        err_val = ERR_ABORT;
                    end
                end
            end
        endcase
        if (err_hit) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            code_d  = (err_code_o == ERR_NONE) ? err_val : err_code_o;
        end
    end

    // State, outputs and request shadow registers.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cfg_valid_o <= 1'b0;
            cfg_addr_o  <= '0;
            cfg_data_o  <= '0;
            cfg_rwn_o   <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= ERR_NONE;
            setup_q     <= '0;
            rx_en_q     <= 1'b0;
            rx_saddr_q  <= '0;
            rx_size_q   <= '0;
            tx_saddr_q  <= '0;
            tx_size_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_valid_o <= valid_d;
            cfg_addr_o  <= addr_d;
            cfg_data_o  <= data_d;
            cfg_rwn_o   <= rwn_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            err_o       <= err_d;
            err_code_o  <= code_d;
            if (latch_c) begin
                setup_q    <= setup_i;
                rx_en_q    <= rx_en_i;
                rx_saddr_q <= rx_saddr_i;
                rx_size_q  <= rx_size_i;
                tx_saddr_q <= tx_saddr_i;
                tx_size_q  <= tx_size_i;
            end
        end
    end

endmodule

// File: tb/tb_udma_uart_cfg_seq.sv
// Self-checking bench for udma_uart_cfg_seq: a UART register-port responder
// with configurable ready latency and STATUS busy count, a vector table of
// whole sequences, and hand-written abort / reset / readback sequences.
module tb_udma_uart_cfg_seq;

    localparam int unsigned AW = 12;
    localparam int unsigned TS = 16;
    localparam int unsigned PT = 4;

    logic          sys_clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0, abort_i = 1'b0, rx_en_i = 1'b0;
    logic [31:0]   setup_i = '0;
    logic [AW-1:0] rx_saddr_i = '0, tx_saddr_i = '0;
    logic [TS-1:0] rx_size_i = '0, tx_size_i = '0;
    logic [31:0]   cfg_data_o, cfg_data_i = '0;
    logic [4:0]    cfg_addr_o;
    logic          cfg_valid_o, cfg_rwn_o, cfg_ready_i = 1'b0;
    logic          busy_o, done_o, err_o;
    logic [1:0]    err_code_o;

    udma_uart_cfg_seq #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .POLL_TIMEOUT(PT)) dut (
        .sys_clk_i(sys_clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .setup_i(setup_i), .rx_en_i(rx_en_i), .rx_saddr_i(rx_saddr_i), .rx_size_i(rx_size_i),
        .tx_saddr_i(tx_saddr_i), .tx_size_i(tx_size_i), .cfg_data_o(cfg_data_o),
        .cfg_addr_o(cfg_addr_o), .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o),
        .cfg_ready_i(cfg_ready_i), .cfg_data_i(cfg_data_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o));

    always #5 sys_clk_i = ~sys_clk_i;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        rwn;
    } rec_t;

    typedef struct {
        logic [31:0]   setup;
        logic          rx_en;
        logic [AW-1:0] rx_saddr;
        logic [TS-1:0] rx_size;
        logic [AW-1:0] tx_saddr;
        logic [TS-1:0] tx_size;
        int            delay;
        int            polls;
        int            exp_cyc;
        int            exp_cyc_rb;
        logic [1:0]    exp_code;
    } vec_t;

    rec_t        rec_q[$];
    rec_t        exp_q[$];
    vec_t        vecs[5];
    logic [31:0] mem[32];
    int          total = 0, bad = 0;
    int          ready_delay = 0, waited = 0, busy_left = 0;
    int          stab_err = 0, gap_err = 0;
    bit          corrupt_setup = 1'b0, pend = 1'b0;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        p_rwn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // UART responder: ready after ready_delay waiting cycles, logs accepted transactions.
    always @(negedge sys_clk_i) begin
        if (cfg_valid_o && cfg_ready_i) gap_err++;
        cfg_ready_i = 1'b0;
        cfg_data_i  = 32'h0;
        if (cfg_valid_o) begin
            if (pend && (cfg_addr_o !== p_addr || cfg_data_o !== p_data || cfg_rwn_o !== p_rwn))
                stab_err++;
            if (waited >= ready_delay) begin
                rec_t r;
                cfg_ready_i = 1'b1;
                pend   = 1'b0;
                waited = 0;
                if (cfg_rwn_o) begin
                    if (cfg_addr_o == 5'h08) begin
                        if (busy_left > 0) begin
                            busy_left--;
                            cfg_data_i = 32'h1;
                        end
                    end else if (corrupt_setup && cfg_addr_o == 5'h09) begin
                        cfg_data_i = 32'h0000_DEAD;
                    end else begin
                        cfg_data_i = mem[cfg_addr_o];
                    end
                end else begin
                    mem[cfg_addr_o] = cfg_data_o;
                end
                r.addr = cfg_addr_o;
                r.data = cfg_data_o;
                r.rwn  = cfg_rwn_o;
                rec_q.push_back(r);
            end else begin
                waited++;
                pend   = 1'b1;
                p_addr = cfg_addr_o;
                p_data = cfg_data_o;
                p_rwn  = cfg_rwn_o;
            end
        end else begin
            pend   = 1'b0;
            waited = 0;
        end
    end

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d, input logic rw);
        rec_t r;
        r.addr = a;
        r.data = d;
        r.rwn  = rw;
        exp_q.push_back(r);
    endtask

    // Write, then (with readback) the matching read of the same address.
    task automatic push_chk(input logic [4:0] a, input logic [31:0] d);
        push_exp(a, d, 1'b0);
`ifdef UDMA_UART_CFG_SEQ_READBACK_EN
        push_exp(a, 32'h0, 1'b1);
`endif
    endtask

    task automatic build_exp(input vec_t v);
        int npoll;
        exp_q.delete();
        push_chk(5'h09, v.setup);
        if (v.rx_en) begin
            push_chk(5'h00, 32'(v.rx_saddr));
            push_chk(5'h01, 32'(v.rx_size));
            push_exp(5'h02, 32'h10, 1'b0);
        end
        push_chk(5'h04, 32'(v.tx_saddr));
        push_chk(5'h05, 32'(v.tx_size));
        push_exp(5'h06, 32'h10, 1'b0);
        npoll = (v.exp_code == 2'd1) ? int'(PT) : v.polls + 1;
        for (int i = 0; i < npoll; i++) push_exp(5'h08, 32'h0, 1'b1);
    endtask

    task automatic compare_recs(input string tag);
        check({tag, "_count"}, rec_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
            check($sformatf("%s_rec%0d_addr", tag, i), rec_q[i].addr, exp_q[i].addr);
            check($sformatf("%s_rec%0d_rwn", tag, i), rec_q[i].rwn, exp_q[i].rwn);
            if (!exp_q[i].rwn)
                check($sformatf("%s_rec%0d_data", tag, i), rec_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic drive_fields(input vec_t v);
        setup_i    = v.setup;
        rx_en_i    = v.rx_en;
        rx_saddr_i = v.rx_saddr;
        rx_size_i  = v.rx_size;
        tx_saddr_i = v.tx_saddr;
        tx_size_i  = v.tx_size;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    k, done_k, ndone, exp_cyc;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge sys_clk_i); #1;
        rec_q.delete();
        build_exp(v);
        ready_delay = v.delay;
        busy_left   = v.polls;
        drive_fields(v);
        start_i = 1'b1;
        k = 0; done_k = 0; ndone = 0;
        while (1) begin
            @(negedge sys_clk_i); #1;
            k++;
            if (k == 1) begin
                // Inputs change after start: shadow copies must be used.
                start_i    = 1'b0;
                setup_i    = ~v.setup;
                rx_en_i    = ~v.rx_en;
                rx_saddr_i = ~v.rx_saddr;
                rx_size_i  = ~v.rx_size;
                tx_saddr_i = ~v.tx_saddr;
                tx_size_i  = ~v.tx_size;
            end
            if (k == 3) start_i = 1'b1;
            if (k == 4) start_i = 1'b0;
            if (done_o) begin
                ndone++;
                if (done_k == 0) done_k = k;
            end
            if (!busy_o || k >= 500) break;
        end
        check({tag, "_terminated"}, (k < 500) ? 1 : 0, 1);
`ifdef UDMA_UART_CFG_SEQ_READBACK_EN
        exp_cyc = v.exp_cyc_rb;
`else
        exp_cyc = v.exp_cyc;
`endif
        check({tag, "_done_pulses"}, ndone, (v.exp_code == 2'd0) ? 1 : 0);
        if (v.exp_code == 2'd0) check({tag, "_done_cycle"}, done_k, exp_cyc);
        check({tag, "_err_o"}, err_o, (v.exp_code != 2'd0) ? 1 : 0);
        check({tag, "_err_code"}, err_code_o, v.exp_code);
        compare_recs(tag);
    endtask

    initial begin
        vec_t vabt;
        int   k;
        bit   saw5, aborted, post_pending, post_done, seen_done;

        for (int i = 0; i < 32; i++) mem[i] = '0;
        vecs[0] = '{32'h0036_0306, 1'b0, 12'h000, 16'h0000, 12'h100, 16'h0005, 0, 0,   12, 18, 2'd0};
        vecs[1] = '{32'h0000_1234, 1'b1, 12'h200, 16'h0008, 12'h300, 16'h0020, 0, 0,   18, 28, 2'd0};
        vecs[2] = '{32'hA5A5_0001, 1'b1, 12'h2F0, 16'hFFFF, 12'hABC, 16'h0001, 3, 0,   42, 67, 2'd0};
        vecs[3] = '{32'h0000_0001, 1'b0, 12'h000, 16'h0000, 12'h040, 16'h0004, 0, 100,  0,  0, 2'd1};
        vecs[4] = '{32'hFFFF_FFFF, 1'b0, 12'h000, 16'h0000, 12'hFFF, 16'hFFFF, 1, 2,   23, 32, 2'd0};

        // Reset values.
        repeat (3) @(negedge sys_clk_i);
        #1;
        check("rst_valid", cfg_valid_o, 0);
        check("rst_addr", cfg_addr_o, 0);
        check("rst_data", cfg_data_o, 0);
        check("rst_rwn", cfg_rwn_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_code", err_code_o, 0);
        rst_i = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Abort while TX_SADDR write waits for ready.
        vabt = '{32'h0000_00AA, 1'b0, 12'h000, 16'h0000, 12'h123, 16'h0007, 3, 0, 0, 0, 2'd2};
        exp_q.delete();
        push_chk(5'h09, vabt.setup);
        push_exp(5'h04, 32'h123, 1'b0);
        @(negedge sys_clk_i); #1;
        rec_q.delete();
        ready_delay = 3;
        busy_left   = 0;
        drive_fields(vabt);
        start_i = 1'b1;
        saw5 = 0; aborted = 0; post_pending = 0; post_done = 0; seen_done = 0;
        for (k = 1; k <= 300; k++) begin
            @(negedge sys_clk_i); #1;
            if (k == 1) start_i = 1'b0;
            if (done_o) seen_done = 1;
            if (cfg_valid_o && cfg_addr_o == 5'h05) saw5 = 1;
            if (post_pending) begin
                check("abort_busy_next", busy_o, 0);
                check("abort_valid_next", cfg_valid_o, 0);
                post_done = 1;
                break;
            end
            if (!aborted && cfg_valid_o && cfg_addr_o == 5'h04 && !cfg_rwn_o) begin
                abort_i = 1'b1;
                aborted = 1;
            end
            if (aborted && rec_q.size() > 0 && rec_q[rec_q.size()-1].addr == 5'h04)
                post_pending = 1;
        end
        check("abort_reached", post_done, 1);
        repeat (4) begin
            @(negedge sys_clk_i); #1;
            if (cfg_valid_o && cfg_addr_o == 5'h05) saw5 = 1;
            if (done_o) seen_done = 1;
        end
        abort_i = 1'b0;
        check("abort_no_tx_size", saw5, 0);
        check("abort_no_done", seen_done, 0);
        check("abort_err_o", err_o, 1);
        check("abort_code", err_code_o, 2);
        compare_recs("abort");

        // Start together with abort in IDLE is ignored; earlier error stays.
        rec_q.delete();
        ready_delay = 0;
        abort_i = 1'b1;
        start_i = 1'b1;
        @(negedge sys_clk_i); #1;
        start_i = 1'b0;
        abort_i = 1'b0;
        repeat (2) @(negedge sys_clk_i);
        #1;
        check("startabort_busy", busy_o, 0);
        check("startabort_recs", rec_q.size(), 0);
        check("startabort_code", err_code_o, 2);

        // Asynchronous reset in the middle of a transaction.
        rec_q.delete();
        drive_fields(vecs[0]);
        busy_left = 0;
        start_i = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(negedge sys_clk_i); #1;
            if (j == 1) start_i = 1'b0;
        end
        check("prerst_valid", cfg_valid_o, 1);
        rst_i = 1'b1;
        #1;
        check("midrst_valid", cfg_valid_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_code", err_code_o, 0);
        @(negedge sys_clk_i); #1;
        rst_i = 1'b0;
        run_vec(vecs[0], 5);

`ifdef UDMA_UART_CFG_SEQ_READBACK_EN
        // Corrupted SETUP readback stops the sequence before any TX write.
        exp_q.delete();
        push_exp(5'h09, vecs[0].setup, 1'b0);
        push_exp(5'h09, 32'h0, 1'b1);
        @(negedge sys_clk_i); #1;
        rec_q.delete();
        corrupt_setup = 1'b1;
        drive_fields(vecs[0]);
        start_i = 1'b1;
        for (k = 1; k <= 300; k++) begin
            @(negedge sys_clk_i); #1;
            if (k == 1) start_i = 1'b0;
            if (!busy_o) break;
        end
        corrupt_setup = 1'b0;
        check("rdbk_terminated", (k <= 300) ? 1 : 0, 1);
        check("rdbk_err_o", err_o, 1);
        check("rdbk_code", err_code_o, 3);
        compare_recs("rdbk");
`endif

        check("hold_stable", stab_err, 0);
        check("valid_gap", gap_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
